// File: rtl/timer_entry_pkg.sv
// Shared definitions for the keypad timer-entry block: state encoding, BCD width
// and the one-hot to BCD conversion used by the key encoder.
package timer_entry_pkg;

   localparam int BCD_W   = 4;
   localparam int KEY_W   = 10;
   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] IDLE         = 2'd0;
   localparam logic [STATE_W-1:0] DEBOUNCE     = 2'd1;
   localparam logic [STATE_W-1:0] LOAD         = 2'd2;
   localparam logic [STATE_W-1:0] WAIT_RELEASE = 2'd3;

   // Multi-hot inputs are screened out by the caller; the highest set bit wins here.
   function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [KEY_W-1:0] k);
      logic [BCD_W-1:0] r;
      r = '0;
      for (int i = 0; i < KEY_W; i++) begin
         if (k[i]) r = BCD_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/timer_entry_key_encoder.sv
// Combinational keypad encoder: 10-bit one-hot key levels to a BCD digit plus an
// exactly-one-bit-set flag.
module key_encoder
   import timer_entry_pkg::*;
(
   input  logic [KEY_W-1:0] key,
   output logic [BCD_W-1:0] bcd,
   output logic             valid
);

   assign bcd   = onehot_to_bcd(key);
   assign valid = (key != '0) && ((key & (key - 10'd1)) == '0);

endmodule

// File: rtl/timer_entry.sv
// Keypad producer for the 3-digit BCD countdown timer: debounces keys, strobes one
// digit per press, drives the timer clear. Optional: LEADING_ZERO_SUPPRESS_EN.
module timer_entry
   import timer_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_DIGITS      = 3,
   parameter int CNT_W           = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [9:0]       key,
   input  logic             lock,
   input  logic             cancel,
   output logic             loadn,
   output logic [3:0]       data,
   output logic             timer_clrn,
   output logic [CNT_W-1:0] digits,
   output logic             full
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_D   = CNT_W'(MAX_DIGITS);

   logic [STATE_W-1:0] state;
   logic [KEY_W-1:0]   key_lat;
   logic [CNT_W-1:0]   cnt;
   logic               cancel_q;
   logic [BCD_W-1:0]   key_bcd;
   logic               key_valid;
   logic               key_multi;
   logic               zero_skip;

   key_encoder u_key_encoder (
      .key   (key),
      .bcd   (key_bcd),
      .valid (key_valid)
   );

   assign key_multi = (key != '0) && !key_valid;

`ifdef LEADING_ZERO_SUPPRESS_EN
   assign zero_skip = (key_lat == 10'd1) && (digits == '0);
`else
   assign zero_skip = 1'b0;
`endif

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state      <= IDLE;
         key_lat    <= '0;
         cnt        <= '0;
         cancel_q   <= 1'b0;
         loadn      <= 1'b1;
         data       <= '0;
         timer_clrn <= 1'b1;
         digits     <= '0;
         full       <= 1'b0;
      end else begin
         // Clear pulses only on the rising edge of the sampled cancel level.
         cancel_q   <= cancel;
         timer_clrn <= !(cancel && !cancel_q);
         if (cancel) begin
            digits <= '0;
            full   <= 1'b0;
            cnt    <= '0;
            loadn  <= 1'b1;
            data   <= '0;
            state  <= (key != '0) ? WAIT_RELEASE : IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (key_valid && !lock) begin
                     state   <= DEBOUNCE;
                     key_lat <= key;
                     cnt     <= '0;
                  end else if (key_multi) begin
                     state <= WAIT_RELEASE;
                  end
               end
               DEBOUNCE: begin
                  if (lock || key == '0) begin
                     state <= IDLE;
                  end else if (key_multi) begin
                     state <= WAIT_RELEASE;
                  end else if (key == key_lat) begin
                     if (cnt == DB_LAST) begin
                        if (full || zero_skip) begin
                           state <= WAIT_RELEASE;
                        end else begin
                           state <= LOAD;
                           loadn <= 1'b0;
                           data  <= key_bcd;
                        end
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else begin
                     key_lat <= key;
                     cnt     <= '0;
                  end
               end
               LOAD: begin
                  loadn <= 1'b1;
                  if (!full) begin
                     digits <= digits + 1'b1;
                     full   <= ((digits + 1'b1) == MAX_D);
                  end
                  state <= WAIT_RELEASE;
               end
               WAIT_RELEASE: begin
                  if (key == '0) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
